fn_logic_unit: RTL

FN_LOGIC_UNIT -- requirements
Module: fn_logic_unit

---
 rtl/fn_pkg.sv | 16 +
 rtl/fn_shift_step.sv | 17 +
 rtl/fn_logic_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/fn_pkg.sv
// fn_pkg: op codes, FSM state encoding and op-class helpers for fn_logic_unit
package fn_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_shift(input logic [2:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA};
  endfunction
  function automatic logic is_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/fn_shift_step.sv
// fn_shift_step: combinational single-step shifter (d, amt, mode) -> q
// Ports: d operand, amt shift amount (0..WIDTH), mode op code selecting SLL/SRL/SRA, q result.
module fn_shift_step
  import fn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         d,
  input  logic [$clog2(WIDTH):0]   amt,
  input  logic [2:0]               mode,
  output logic [WIDTH-1:0]         q
);
  logic [WIDTH-1:0] sra;
  // kept in its own assignment so the ternary below cannot make it unsigned
  assign sra = $signed(d) >>> amt;
  always_comb q = mode == OP_SLL ? d << amt : mode == OP_SRA ? sra : d >> amt;
endmodule

// File: rtl/fn_logic_unit.sv
// fn_logic_unit: bitwise/shift unit with valid/ready handshake and a STEP-bits-per-cycle shifter
// Ports: clk, rst_n (synchronous, active-low); request in_valid/in_ready/op/a/b;
//        result out_valid/out_ready/y/err; op_count only when FN_LOGIC_CNT_EN is defined.
module fn_logic_unit
  import fn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FN_LOGIC_CNT_EN
  output logic [15:0]      op_count,
`endif
  output logic [WIDTH-1:0] y,
  output logic             err
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [SH:0] STEP_W = STEP[SH:0];
  state_t state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, step_y;
  logic err_q, err_d, rem_le;
  logic [SH-1:0] rem_q, rem_d, shamt;
  logic [SH:0] amt;
  logic [2:0] op_q, op_d;
  assign shamt = b[SH-1:0];
  // the last step takes whatever is left, never more than STEP
  assign rem_le = {1'b0, rem_q} <= STEP_W;
  assign amt = rem_le ? {1'b0, rem_q} : STEP_W;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign y = y_q;
  assign err = err_q;
  fn_shift_step #(.WIDTH(WIDTH)) u_step (
    .d(y_q),
    .amt(amt),
    .mode(op_q),
    .q(step_y)
  );
  always_comb begin
    state_d = state_q;
    y_d = y_q;
    err_d = err_q;
    rem_d = rem_q;
    op_d = op_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d = op;
        err_d = is_reserved(op);
        rem_d = is_shift(op) ? shamt : '0;
        y_d = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : is_shift(op) ? a : '0;
        state_d = is_shift(op) && shamt != '0 ? SHIFT : DONE;
      end
      SHIFT: begin
        y_d = step_y;
        rem_d = rem_q - amt[SH-1:0];
        state_d = rem_le ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q <= '0;
      err_q <= 1'b0;
      rem_q <= '0;
      op_q <= OP_AND;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      err_q <= err_d;
      rem_q <= rem_d;
      op_q <= op_d;
    end
  end
`ifdef FN_LOGIC_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) op_count <= '0;
    else if (out_valid && out_ready) op_count <= op_count + 16'd1;
  end
`endif
endmodule
